// File: rtl/fixed_point_mul_pipe_pkg.sv
// Shared types and Q-format helpers for the fixed-point multiply pipeline.
package fixed_point_pkg;

  // Rounding applied when the 2*WIDTH product is rescaled back to WIDTH bits.
  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  // Largest representable signed value of a WIDTH-bit word.
  function automatic longint q_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest representable signed value of a WIDTH-bit word.
  function automatic longint q_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/fixed_point_mul_pipe_if.sv
// Beat-level bus of the multiplier: packed lane operands, handshake and results.
interface fixed_point_mul_pipe_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  import fixed_point_pkg::*;

  logic [LANES*WIDTH-1:0] VALUE_A_IN;
  logic [LANES*WIDTH-1:0] VALUE_B_IN;
  round_mode_e            ROUND_MODE_IN;
  logic                   VALID_IN;
  logic                   READY_OUT;
  logic [LANES*WIDTH-1:0] VALUE_OUT;
  logic [LANES-1:0]       OVERFLOW_OUT;
  logic                   VALID_OUT;
  logic                   READY_IN;

  // Multiplier side.
  modport slave (
    input  VALUE_A_IN, VALUE_B_IN, ROUND_MODE_IN, VALID_IN, READY_IN,
    output READY_OUT, VALUE_OUT, OVERFLOW_OUT, VALID_OUT
  );

  // Producer/consumer side.
  modport master (
    output VALUE_A_IN, VALUE_B_IN, ROUND_MODE_IN, VALID_IN, READY_IN,
    input  READY_OUT, VALUE_OUT, OVERFLOW_OUT, VALID_OUT
  );

endinterface

// File: rtl/fixed_point_mul_pipe_round_sat.sv
// One lane of stage 2: rescale the product, range check, then clamp or wrap.
module fixed_point_round_sat
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3,
  parameter int SATURATE  = 1
) (
  input  logic [2*WIDTH-1:0] prod_i,
  input  round_mode_e        mode_i,
  output logic [WIDTH-1:0]   value_o,
  output logic               ovf_o
);

  // One guard bit above the product so the rounding add can never overflow.
  localparam int EXT_W = 2 * WIDTH + 1;
  localparam logic signed [EXT_W-1:0] MAX_EXT  = EXT_W'(q_max(WIDTH));
  localparam logic signed [EXT_W-1:0] MIN_EXT  = EXT_W'(q_min(WIDTH));
  localparam logic signed [EXT_W-1:0] HALF_EXT = EXT_W'(64'sd1 <<< (FRAC_BITS - 1));

  logic signed [EXT_W-1:0] sum_s;
  logic signed [EXT_W-1:0] res_s;

  // Rescale with optional half-up bias, then decide between in-range, clamp and wrap.
  always_comb begin
    sum_s   = '0;
    res_s   = '0;
    ovf_o   = 1'b0;
    value_o = '0;
    if (mode_i == RND_HALF_UP) begin
      sum_s = $signed({prod_i[2*WIDTH-1], prod_i}) + HALF_EXT;
    end else begin
      sum_s = $signed({prod_i[2*WIDTH-1], prod_i});
    end
    res_s = sum_s >>> FRAC_BITS;
    ovf_o = (res_s > MAX_EXT) || (res_s < MIN_EXT);
    if (ovf_o && (SATURATE != 0)) begin
      if (res_s[EXT_W-1]) begin
        value_o = MIN_EXT[WIDTH-1:0];
      end else begin
        value_o = MAX_EXT[WIDTH-1:0];
      end
    end else begin
      value_o = res_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_mul_pipe.sv
// Two-stage multi-lane signed fixed-point multiplier with valid/ready backpressure.
module fixed_point_mul_pipe
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3,
  parameter int LANES     = 4,
  parameter int SATURATE  = 1
) (
  input logic                    CLK,
  input logic                    RST,
  fixed_point_mul_pipe_if.slave  bus
);

  localparam int PW = 2 * WIDTH;

  logic                         adv_s;
  logic [LANES-1:0][PW-1:0]     prod_d;
  logic [LANES-1:0][PW-1:0]     prod_q;
  round_mode_e                  mode_q;
  logic                         valid1_q;
  logic [LANES-1:0][WIDTH-1:0]  value_d;
  logic [LANES-1:0][WIDTH-1:0]  value_q;
  logic [LANES-1:0]             ovf_d;
  logic [LANES-1:0]             ovf_q;
  logic                         valid2_q;

  // The whole pipe moves in lockstep; it only freezes when a held result is refused.
  assign adv_s            = !valid2_q || bus.READY_IN;
  assign bus.READY_OUT    = adv_s;
  assign bus.VALUE_OUT    = value_q;
  assign bus.OVERFLOW_OUT = ovf_q;
  assign bus.VALID_OUT    = valid2_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0] a_ext_s;
    logic [PW-1:0] b_ext_s;

    // Sign-extend to full product width; the low PW bits of the product are then exact.
    assign a_ext_s   = {{WIDTH{bus.VALUE_A_IN[i*WIDTH+WIDTH-1]}}, bus.VALUE_A_IN[i*WIDTH +: WIDTH]};
    assign b_ext_s   = {{WIDTH{bus.VALUE_B_IN[i*WIDTH+WIDTH-1]}}, bus.VALUE_B_IN[i*WIDTH +: WIDTH]};
    assign prod_d[i] = a_ext_s * b_ext_s;

    fixed_point_round_sat #(
      .WIDTH     (WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .SATURATE  (SATURATE)
    ) u_round_sat (
      .prod_i  (prod_q[i]),
      .mode_i  (mode_q),
      .value_o (value_d[i]),
      .ovf_o   (ovf_d[i])
    );
  end

  // Stage 1: capture raw products with the beat's rounding mode and valid bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prod_q   <= '0;
      mode_q   <= RND_TRUNC;
      valid1_q <= 1'b0;
    end else if (adv_s) begin
      prod_q   <= prod_d;
      mode_q   <= bus.ROUND_MODE_IN;
      valid1_q <= bus.VALID_IN;
    end
  end

  // Stage 2: capture rescaled results and flags; held steady while stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      value_q  <= '0;
      ovf_q    <= '0;
      valid2_q <= 1'b0;
    end else if (adv_s) begin
      value_q  <= value_d;
      ovf_q    <= ovf_d;
      valid2_q <= valid1_q;
    end
  end

endmodule
